// File: rtl/seq_step_pkg.sv
// Shared types and constants for the step-sequencer arbiter.
// Macro STEP_ABORT_EN (optional) enables the abort path in the arbiter and its interface.
package seq_step_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_STEP = 2'd1;
  localparam state_t ST_WAIT = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  localparam logic [1:0] PH_A = 2'd0;
  localparam logic [1:0] PH_B = 2'd1;
  localparam logic [1:0] PH_C = 2'd2;
  localparam logic [1:0] PH_D = 2'd3;

  typedef logic req_id_t;

endpackage

// File: rtl/seq_step_arbiter_if.sv
// Requester handshakes and sequencer-side outputs of the step arbiter.
// Macro STEP_ABORT_EN adds the abort input and done_aborted output.
interface seq_step_arbiter_if #(
  parameter int unsigned CNT_W = 8
);
  logic             req0_valid;
  logic [CNT_W-1:0] req0_steps;
  logic             req0_ready;
  logic             req1_valid;
  logic [CNT_W-1:0] req1_steps;
  logic             req1_ready;
  logic             en;
  logic [1:0]       phase;
  logic             phase_d;
  logic             busy;
  logic [1:0]       grant;
  logic             done;
  logic             done_id;
`ifdef STEP_ABORT_EN
  logic             abort;
  logic             done_aborted;
`endif

  modport master (
    output req0_valid, req0_steps, req1_valid, req1_steps,
`ifdef STEP_ABORT_EN
    output abort,
    input  done_aborted,
`endif
    input  req0_ready, req1_ready, en, phase, phase_d, busy, grant, done, done_id
  );

  modport slave (
    input  req0_valid, req0_steps, req1_valid, req1_steps,
`ifdef STEP_ABORT_EN
    input  abort,
    output done_aborted,
`endif
    output req0_ready, req1_ready, en, phase, phase_d, busy, grant, done, done_id
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin pick; on a tie the requester that did not win last time is chosen.
module rr_arb2
  import seq_step_pkg::*;
(
  input  logic [1:0] i_valid,
  input  req_id_t    i_last_id,
  output logic [1:0] o_sel,
  output req_id_t    o_sel_id
);

  always_comb begin
    o_sel_id = 1'b0;
    case (i_valid)
      2'b01:   o_sel_id = 1'b0;
      2'b10:   o_sel_id = 1'b1;
      2'b11:   o_sel_id = ~i_last_id;
      default: o_sel_id = 1'b0;
    endcase
    o_sel = 2'b00;
    if (i_valid != 2'b00) o_sel = o_sel_id ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/seq_step_arbiter.sv
// Round-robin scheduler driving a shared 4-phase step sequencer with gapped enable pulses.
// Macro STEP_ABORT_EN adds an abort input that ends the running command early.
module seq_step_arbiter
  import seq_step_pkg::*;
#(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned GAP   = 1
) (
  input logic               clk,
  input logic               rst,
  seq_step_arbiter_if.slave bus
);

  localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  state_t           r_state,     w_state_nxt;
  logic [1:0]       r_phase,     w_phase_nxt;
  logic [CNT_W-1:0] r_remaining, w_rem_nxt;
  logic [GAP_W-1:0] r_gap,       w_gap_nxt;
  req_id_t          r_last_id,   w_last_nxt;
  req_id_t          r_owner,     w_owner_nxt;
  logic [1:0]       r_grant,     w_grant_nxt;
`ifdef STEP_ABORT_EN
  logic             r_aborted,   w_aborted_nxt;
`endif

  logic [1:0]       w_sel;
  req_id_t          w_sel_id;
  logic             w_idle;
  logic             w_accept;
  logic             w_abort;
  logic [CNT_W-1:0] w_steps;

  rr_arb2 u_rr_arb2 (
    .i_valid   ({bus.req1_valid, bus.req0_valid}),
    .i_last_id (r_last_id),
    .o_sel     (w_sel),
    .o_sel_id  (w_sel_id)
  );

  assign w_idle         = (r_state == ST_IDLE);
  assign w_accept       = w_idle && (w_sel != 2'b00);
  assign w_steps        = w_sel_id ? bus.req1_steps : bus.req0_steps;
  assign bus.req0_ready = w_idle && w_sel[0];
  assign bus.req1_ready = w_idle && w_sel[1];

`ifdef STEP_ABORT_EN
  assign w_abort = bus.abort;
`else
  assign w_abort = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_phase_nxt   = r_phase;
    w_rem_nxt     = r_remaining;
    w_gap_nxt     = r_gap;
    w_last_nxt    = r_last_id;
    w_owner_nxt   = r_owner;
    w_grant_nxt   = r_grant;
`ifdef STEP_ABORT_EN
    w_aborted_nxt = r_aborted;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_rem_nxt   = w_steps;
          w_grant_nxt = w_sel;
          w_owner_nxt = w_sel_id;
          w_state_nxt = (w_steps != '0) ? ST_STEP : ST_DONE;
`ifdef STEP_ABORT_EN
          w_aborted_nxt = 1'b0;
`endif
        end
      end
      ST_STEP: begin
        // The enable of this cycle is issued even when an abort is sampled.
        w_phase_nxt = r_phase + 2'd1;
        w_rem_nxt   = r_remaining - CNT_W'(1);
        if (w_abort || (r_remaining == CNT_W'(1))) begin
          w_state_nxt = ST_DONE;
`ifdef STEP_ABORT_EN
          w_aborted_nxt = w_abort;
`endif
        end else if (GAP == 0) begin
          w_state_nxt = ST_STEP;
        end else begin
          w_state_nxt = ST_WAIT;
          w_gap_nxt   = GAP_LOAD;
        end
      end
      ST_WAIT: begin
        if (w_abort) begin
          w_state_nxt = ST_DONE;
`ifdef STEP_ABORT_EN
          w_aborted_nxt = 1'b1;
`endif
        end else if (r_gap == '0) begin
          w_state_nxt = ST_STEP;
        end else begin
          w_gap_nxt = r_gap - GAP_W'(1);
        end
      end
      ST_DONE: begin
        w_last_nxt  = r_owner;
        w_grant_nxt = 2'b00;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_phase     <= PH_A;
      r_remaining <= '0;
      r_gap       <= '0;
      r_last_id   <= 1'b1;
      r_owner     <= 1'b0;
      r_grant     <= 2'b00;
`ifdef STEP_ABORT_EN
      r_aborted   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_remaining <= w_rem_nxt;
      r_gap       <= w_gap_nxt;
      r_last_id   <= w_last_nxt;
      r_owner     <= w_owner_nxt;
      r_grant     <= w_grant_nxt;
`ifdef STEP_ABORT_EN
      r_aborted   <= w_aborted_nxt;
`endif
    end
  end

  assign bus.en      = (r_state == ST_STEP);
  assign bus.phase   = r_phase;
  assign bus.phase_d = (r_phase == PH_D);
  assign bus.busy    = !w_idle;
  assign bus.grant   = r_grant;
  assign bus.done    = (r_state == ST_DONE);
  assign bus.done_id = (r_state == ST_DONE) && r_owner;
`ifdef STEP_ABORT_EN
  assign bus.done_aborted = (r_state == ST_DONE) && r_aborted;
`endif

endmodule

// File: tb/tb_seq_step_arbiter.sv
// Directed bench for seq_step_arbiter: GAP=1 and GAP=0 instances observed through one view.
// Abort test runs only when STEP_ABORT_EN is defined.
module tb_seq_step_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       use_g0;
  logic       v0, v1;
  logic [7:0] s0, s1;
`ifdef STEP_ABORT_EN
  logic       ab;
`endif

  always #5 clk = ~clk;

  seq_step_arbiter_if #(.CNT_W(8)) if_g1 ();
  seq_step_arbiter_if #(.CNT_W(8)) if_g0 ();

  assign if_g1.req0_valid = v0;
  assign if_g1.req0_steps = s0;
  assign if_g1.req1_valid = v1;
  assign if_g1.req1_steps = s1;
  assign if_g0.req0_valid = v0;
  assign if_g0.req0_steps = s0;
  assign if_g0.req1_valid = v1;
  assign if_g0.req1_steps = s1;
`ifdef STEP_ABORT_EN
  assign if_g1.abort = ab;
  assign if_g0.abort = ab;
`endif

  seq_step_arbiter #(.CNT_W(8), .GAP(1)) u_dut_g1 (
    .clk (clk),
    .rst (rst),
    .bus (if_g1)
  );

  seq_step_arbiter #(.CNT_W(8), .GAP(0)) u_dut_g0 (
    .clk (clk),
    .rst (rst),
    .bus (if_g0)
  );

  logic       m_en, m_phase_d, m_busy, m_done, m_done_id, m_r0, m_r1, m_ab;
  logic [1:0] m_phase, m_grant;

  always_comb begin
    m_en      = use_g0 ? if_g0.en         : if_g1.en;
    m_phase   = use_g0 ? if_g0.phase      : if_g1.phase;
    m_phase_d = use_g0 ? if_g0.phase_d    : if_g1.phase_d;
    m_busy    = use_g0 ? if_g0.busy       : if_g1.busy;
    m_grant   = use_g0 ? if_g0.grant      : if_g1.grant;
    m_done    = use_g0 ? if_g0.done       : if_g1.done;
    m_done_id = use_g0 ? if_g0.done_id    : if_g1.done_id;
    m_r0      = use_g0 ? if_g0.req0_ready : if_g1.req0_ready;
    m_r1      = use_g0 ? if_g0.req1_ready : if_g1.req1_ready;
`ifdef STEP_ABORT_EN
    m_ab      = use_g0 ? if_g0.done_aborted : if_g1.done_aborted;
`else
    m_ab      = 1'b0;
`endif
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_en"},      m_en,      0);
    check_eq({tag, "_phase"},   m_phase,   0);
    check_eq({tag, "_phase_d"}, m_phase_d, 0);
    check_eq({tag, "_busy"},    m_busy,    0);
    check_eq({tag, "_grant"},   m_grant,   0);
    check_eq({tag, "_done"},    m_done,    0);
    check_eq({tag, "_done_id"}, m_done_id, 0);
    check_eq({tag, "_ready0"},  m_r0,      0);
    check_eq({tag, "_ready1"},  m_r1,      0);
  endtask

  // Called at the negedge of cycle 1 (acceptance edge is cycle 0); returns at the done cycle.
  task automatic run_cmd(input int limit, input int abort_cyc, output logic [31:0] en_mask,
                         output int done_cyc, output logic [1:0] first_grant,
                         output int phd_cnt, output logic done_id, output logic done_ab);
    en_mask     = '0;
    done_cyc    = -1;
    phd_cnt     = 0;
    done_id     = 1'b0;
    done_ab     = 1'b0;
    first_grant = m_grant;
    for (int c = 1; c <= limit; c++) begin
      if (m_en && c < 32) en_mask[c] = 1'b1;
      if (m_phase_d) phd_cnt++;
      if (m_done) begin
        done_cyc = c;
        done_id  = m_done_id;
        done_ab  = m_ab;
        break;
      end
`ifdef STEP_ABORT_EN
      ab = (c == abort_cyc);
`else
      if (abort_cyc < 0) $display("abort_cyc ignored");
`endif
      @(negedge clk);
    end
`ifdef STEP_ABORT_EN
    ab = 1'b0;
`endif
  endtask

  logic [31:0] mask;
  int          dc, phd, nd;
  logic [1:0]  g;
  logic        did, dab;

  initial begin
    use_g0 = 1'b0;
    v0 = 1'b0; v1 = 1'b0; s0 = '0; s1 = '0;
`ifdef STEP_ABORT_EN
    ab = 1'b0;
`endif
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;

    // req0, 5 steps, GAP=1
    @(negedge clk);
    v0 = 1'b1; s0 = 8'd5;
    #1;
    check_eq("t1_ready0", m_r0, 1);
    check_eq("t1_ready1", m_r1, 0);
    @(negedge clk);
    v0 = 1'b0;
    run_cmd(40, 0, mask, dc, g, phd, did, dab);
    check_eq("t1_en_mask", mask, 32'h2AA);
    check_eq("t1_done_cyc", dc, 10);
    check_eq("t1_done_id", did, 0);
    check_eq("t1_grant", g, 2'b01);
    check_eq("t1_phase", m_phase, 1);
    @(negedge clk);
    check_eq("t1_idle_busy", m_busy, 0);
    check_eq("t1_idle_grant", m_grant, 0);

    // Tie after reset: req0 first, req1 one IDLE cycle later
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    v0 = 1'b1; s0 = 8'd2; v1 = 1'b1; s1 = 8'd3;
    #1;
    check_eq("t2_ready0", m_r0, 1);
    check_eq("t2_ready1", m_r1, 0);
    @(negedge clk);
    v0 = 1'b0;
    check_eq("t2_ready1_busy", m_r1, 0);
    run_cmd(40, 0, mask, dc, g, phd, did, dab);
    check_eq("t2a_en_mask", mask, 32'hA);
    check_eq("t2a_done_cyc", dc, 4);
    check_eq("t2a_done_id", did, 0);
    check_eq("t2a_grant", g, 2'b01);
    @(negedge clk);
    check_eq("t2_ready1_idle", m_r1, 1);
    check_eq("t2_idle_grant", m_grant, 0);
    @(negedge clk);
    v1 = 1'b0;
    run_cmd(40, 0, mask, dc, g, phd, did, dab);
    check_eq("t2b_en_mask", mask, 32'h2A);
    check_eq("t2b_done_cyc", dc, 6);
    check_eq("t2b_done_id", did, 1);
    check_eq("t2b_grant", g, 2'b10);
    check_eq("t2b_phase", m_phase, 1);

    // Zero-step command
    @(negedge clk);
    v0 = 1'b1; s0 = 8'd0;
    @(negedge clk);
    v0 = 1'b0;
    run_cmd(10, 0, mask, dc, g, phd, did, dab);
    check_eq("t3_en_mask", mask, 0);
    check_eq("t3_done_cyc", dc, 1);
    check_eq("t3_phase", m_phase, 1);

    // GAP=0, 4 steps
    use_g0 = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    v0 = 1'b1; s0 = 8'd4;
    @(negedge clk);
    v0 = 1'b0;
    run_cmd(20, 0, mask, dc, g, phd, did, dab);
    check_eq("t4_en_mask", mask, 32'h1E);
    check_eq("t4_done_cyc", dc, 5);
    check_eq("t4_phase_d_cnt", phd, 1);
    check_eq("t4_phase", m_phase, 0);

    // Reset during WAIT of a 200-step command
    use_g0 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    v0 = 1'b1; s0 = 8'd200;
    @(negedge clk);
    v0 = 1'b0;
    check_eq("t5_en_c1", m_en, 1);
    @(negedge clk);
    check_eq("t5_en_wait", m_en, 0);
    check_eq("t5_busy_wait", m_busy, 1);
    check_eq("t5_phase_wait", m_phase, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("t5");
    rst = 1'b0;
    nd = 0;
    repeat (5) begin
      @(negedge clk);
      if (m_done) nd++;
    end
    check_eq("t5_no_done", nd, 0);

`ifdef STEP_ABORT_EN
    // Abort during the third WAIT of a 10-step command
    @(negedge clk);
    v0 = 1'b1; s0 = 8'd10;
    @(negedge clk);
    v0 = 1'b0;
    run_cmd(40, 6, mask, dc, g, phd, did, dab);
    check_eq("t6_en_mask", mask, 32'h2A);
    check_eq("t6_done_cyc", dc, 7);
    check_eq("t6_done_aborted", dab, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
